execute_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits directly upstream of the memory stage and drives its address/data/byte-enable/reg-dst/wb-control inputs.
- Contains the ALU, HI/LO registers, an iterative multiply/divide unit with hazard interlock, store/load byte-lane generation and the registered EX/MEM latch.

---
 rtl/execute_stage_pkg.sv | 51 +++++
 rtl/execute_stage_muldiv.sv | 167 ++++++++++++++++
 rtl/execute_stage.sv | 152 +++++++++++++++
 tb/tb_execute_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared widths, ALU opcodes, memory size codes and mul/div states
package execute_stage_pkg;

  localparam int NB_ALU_OP  = 5;
  localparam int NB_REG     = 5;
  localparam int NB_CTR_WB  = 2;
  localparam int NB_CTR_MEM = 8;

  typedef enum logic [NB_ALU_OP-1:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MFHI  = 5'd15,
    ALU_MFLO  = 5'd16,
    ALU_MTHI  = 5'd17,
    ALU_MTLO  = 5'd18,
    ALU_MULT  = 5'd19,
    ALU_MULTU = 5'd20,
    ALU_DIV   = 5'd21,
    ALU_DIVU  = 5'd22
  } alu_op_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_hilo_op(input logic [NB_ALU_OP-1:0] op);
    return (op == ALU_MFHI) || (op == ALU_MFLO) || (op == ALU_MTHI) || (op == ALU_MTLO) ||
           (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// rtl/execute_stage_muldiv.sv - HI/LO registers, one-cycle multiplier and restoring divider
module muldiv_unit
  import execute_stage_pkg::*;
#(
  parameter int NB_BITS    = 32,
  parameter int NB_DIV_CYC = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_issue,
  input  logic [NB_ALU_OP-1:0] i_op,
  input  logic [NB_BITS-1:0]   i_rs_data,
  input  logic [NB_BITS-1:0]   i_rt_data,
  output logic [NB_BITS-1:0]   o_hi,
  output logic [NB_BITS-1:0]   o_lo,
  output logic                 o_busy
);

  localparam int NB_CNT = $clog2(NB_DIV_CYC);
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DIV_CYC - 2);

  md_state_e             state_q, state_d;
  logic [NB_BITS-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [NB_BITS-1:0]    a_q, a_d, b_q, b_d;
  logic                  sgn_q, sgn_d;
  logic [NB_BITS-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic [NB_CNT-1:0]     ctr_q, ctr_d;

  logic                  div_signed;
  logic [NB_BITS-1:0]    mag_a, mag_b;
  logic [NB_BITS:0]      shifted, diff;
  logic [NB_BITS-1:0]    step_rem, step_quo;
  logic signed [2*NB_BITS-1:0] a_ext, b_ext;
  logic [2*NB_BITS-1:0]  prod;

  always_comb begin
    div_signed = (i_op == ALU_DIV);
    mag_a = (div_signed && i_rs_data[NB_BITS-1]) ? -i_rs_data : i_rs_data;
    mag_b = (div_signed && i_rt_data[NB_BITS-1]) ? -i_rt_data : i_rt_data;
  end

  // Sign/zero extension to double width makes the truncated product correct for both MULT and MULTU
  always_comb begin
    a_ext = sgn_q ? {{NB_BITS{a_q[NB_BITS-1]}}, a_q} : {{NB_BITS{1'b0}}, a_q};
    b_ext = sgn_q ? {{NB_BITS{b_q[NB_BITS-1]}}, b_q} : {{NB_BITS{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  // quo_q holds the remaining dividend bits on the left and grows quotient bits on the right
  always_comb begin
    shifted = {rem_q, quo_q[NB_BITS-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[NB_BITS]) begin
      step_rem = diff[NB_BITS-1:0];
      step_quo = {quo_q[NB_BITS-2:0], 1'b1};
    end else begin
      step_rem = shifted[NB_BITS-1:0];
      step_quo = {quo_q[NB_BITS-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ctr_d     = ctr_q;
    case (state_q)
      MD_IDLE: begin
        if (i_issue) begin
          case (alu_op_e'(i_op))
            ALU_MTHI: hi_d = i_rs_data;
            ALU_MTLO: lo_d = i_rs_data;
            ALU_MULT, ALU_MULTU: begin
              a_d     = i_rs_data;
              b_d     = i_rt_data;
              sgn_d   = (i_op == ALU_MULT);
              state_d = MD_MUL;
            end
            ALU_DIV, ALU_DIVU: begin
              a_d       = i_rs_data;
              quo_d     = mag_a;
              rem_d     = '0;
              dvs_d     = mag_b;
              neg_quo_d = div_signed && (i_rs_data[NB_BITS-1] ^ i_rt_data[NB_BITS-1]);
              neg_rem_d = div_signed && i_rs_data[NB_BITS-1];
              div0_d    = (i_rt_data == '0);
              ctr_d     = '0;
              state_d   = MD_DIV;
            end
            default: ;
          endcase
        end
      end
      MD_MUL: begin
        hi_d    = prod[2*NB_BITS-1:NB_BITS];
        lo_d    = prod[NB_BITS-1:0];
        state_d = MD_IDLE;
      end
      MD_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (ctr_q == LAST_ITER) state_d = MD_DONE;
        else ctr_d = ctr_q + 1'b1;
      end
      MD_DONE: begin
        // Final iteration folds in sign correction and the divide-by-zero result
        if (div0_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = neg_quo_q ? -step_quo : step_quo;
          hi_d = neg_rem_q ? -step_rem : step_rem;
        end
        ctr_d   = '0;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= MD_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ctr_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ctr_q     <= ctr_d;
    end
  end

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = (state_q != MD_IDLE);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage: ALU, HI/LO interlock, byte lanes and EX/MEM latch
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int NB_BITS    = 32,
  parameter int NB_DIV_CYC = 32,
  parameter int NB_CTR     = NB_CTR_MEM >> 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [NB_BITS-1:0]   i_rs_data,
  input  logic [NB_BITS-1:0]   i_rt_data,
  input  logic [NB_BITS-1:0]   i_imm,
  input  logic [4:0]           i_shamt,
  input  logic                 i_alu_src,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic                 i_mem_write,
  input  logic                 i_mem_read,
  input  logic [1:0]           i_mem_size,
  input  logic [NB_REG-1:0]    i_reg_dst,
  input  logic [NB_CTR_WB-1:0] i_wb_ctl,
  output logic [NB_BITS-1:0]   o_alu_data,
  output logic [NB_BITS-1:0]   o_store_data,
  output logic [NB_CTR-1:0]    o_write_ctl,
  output logic [NB_CTR-1:0]    o_read_ctl,
  output logic [NB_REG-1:0]    o_reg_dst,
  output logic [NB_CTR_WB-1:0] o_wb_ctl,
  output logic                 o_addr_err,
  output logic                 o_stall
);

  logic [NB_BITS-1:0]   hi, lo;
  logic                 busy, stall, issue;
  logic [NB_BITS-1:0]   op_b, alu_res, lane_data;
  logic [NB_CTR-1:0]    lane_en;
  logic                 misaligned, mem_op, addr_err, mem_ok;

  logic [NB_BITS-1:0]   alu_data_q, alu_data_d, store_data_q, store_data_d;
  logic [NB_CTR-1:0]    write_ctl_q, write_ctl_d, read_ctl_q, read_ctl_d;
  logic [NB_REG-1:0]    reg_dst_q, reg_dst_d;
  logic [NB_CTR_WB-1:0] wb_ctl_q, wb_ctl_d;
  logic                 addr_err_q, addr_err_d;

  assign stall = ~i_rst & i_valid & busy & is_hilo_op(i_alu_op);
  assign issue = i_valid & ~stall;

  muldiv_unit #(
    .NB_BITS    (NB_BITS),
    .NB_DIV_CYC (NB_DIV_CYC)
  ) u_muldiv (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_issue   (issue),
    .i_op      (i_alu_op),
    .i_rs_data (i_rs_data),
    .i_rt_data (i_rt_data),
    .o_hi      (hi),
    .o_lo      (lo),
    .o_busy    (busy)
  );

  always_comb begin
    op_b    = i_alu_src ? i_imm : i_rt_data;
    alu_res = '0;
    case (alu_op_e'(i_alu_op))
      ALU_ADD:  alu_res = i_rs_data + op_b;
      ALU_SUB:  alu_res = i_rs_data - op_b;
      ALU_AND:  alu_res = i_rs_data & op_b;
      ALU_OR:   alu_res = i_rs_data | op_b;
      ALU_XOR:  alu_res = i_rs_data ^ op_b;
      ALU_NOR:  alu_res = ~(i_rs_data | op_b);
      ALU_SLT:  alu_res = {{(NB_BITS-1){1'b0}}, $signed(i_rs_data) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(NB_BITS-1){1'b0}}, i_rs_data < op_b};
      ALU_SLL:  alu_res = op_b << i_shamt;
      ALU_SRL:  alu_res = op_b >> i_shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> i_shamt);
      ALU_SLLV: alu_res = op_b << i_rs_data[4:0];
      ALU_SRLV: alu_res = op_b >> i_rs_data[4:0];
      ALU_SRAV: alu_res = $unsigned($signed(op_b) >>> i_rs_data[4:0]);
      ALU_LUI:  alu_res = {i_imm[15:0], {(NB_BITS-16){1'b0}}};
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    lane_en    = '0;
    lane_data  = i_rt_data;
    misaligned = 1'b0;
    case (i_mem_size)
      MEM_BYTE: begin
        lane_en   = NB_CTR'(1) << alu_res[1:0];
        lane_data = {(NB_BITS/8){i_rt_data[7:0]}};
      end
      MEM_HALF: begin
        lane_en    = NB_CTR'(3) << alu_res[1:0];
        lane_data  = {(NB_BITS/16){i_rt_data[15:0]}};
        misaligned = alu_res[0];
      end
      default: begin
        lane_en    = '1;
        misaligned = (alu_res[1:0] != 2'b00);
      end
    endcase
  end

  // Stores win over loads when both are requested
  always_comb begin
    mem_op       = i_mem_write | i_mem_read;
    addr_err     = issue & mem_op & misaligned;
    mem_ok       = issue & ~addr_err;
    alu_data_d   = alu_res;
    store_data_d = lane_data;
    write_ctl_d  = (mem_ok & i_mem_write) ? lane_en : '0;
    read_ctl_d   = (mem_ok & i_mem_read & ~i_mem_write) ? lane_en : '0;
    reg_dst_d    = issue ? i_reg_dst : '0;
    wb_ctl_d     = mem_ok ? i_wb_ctl : '0;
    addr_err_d   = addr_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      alu_data_q   <= '0;
      store_data_q <= '0;
      write_ctl_q  <= '0;
      read_ctl_q   <= '0;
      reg_dst_q    <= '0;
      wb_ctl_q     <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      alu_data_q   <= alu_data_d;
      store_data_q <= store_data_d;
      write_ctl_q  <= write_ctl_d;
      read_ctl_q   <= read_ctl_d;
      reg_dst_q    <= reg_dst_d;
      wb_ctl_q     <= wb_ctl_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign o_alu_data   = alu_data_q;
  assign o_store_data = store_data_q;
  assign o_write_ctl  = write_ctl_q;
  assign o_read_ctl   = read_ctl_q;
  assign o_reg_dst    = reg_dst_q;
  assign o_wb_ctl     = wb_ctl_q;
  assign o_addr_err   = addr_err_q;
  assign o_stall      = stall;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage with a behavioural reference model
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0, imm = '0;
  logic [4:0]  shamt = '0;
  logic        alu_src = 1'b0;
  logic [4:0]  alu_op = '0;
  logic        mem_write = 1'b0, mem_read = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [4:0]  reg_dst = '0;
  logic [1:0]  wb_ctl = '0;
  logic [31:0] o_alu_data, o_store_data;
  logic [3:0]  o_write_ctl, o_read_ctl;
  logic [4:0]  o_reg_dst;
  logic [1:0]  o_wb_ctl;
  logic        o_addr_err, o_stall;

  always #5 clk = ~clk;

  execute_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rs_data(rs_data), .i_rt_data(rt_data),
    .i_imm(imm), .i_shamt(shamt), .i_alu_src(alu_src), .i_alu_op(alu_op),
    .i_mem_write(mem_write), .i_mem_read(mem_read), .i_mem_size(mem_size),
    .i_reg_dst(reg_dst), .i_wb_ctl(wb_ctl), .o_alu_data(o_alu_data),
    .o_store_data(o_store_data), .o_write_ctl(o_write_ctl), .o_read_ctl(o_read_ctl),
    .o_reg_dst(o_reg_dst), .o_wb_ctl(o_wb_ctl), .o_addr_err(o_addr_err), .o_stall(o_stall)
  );

  typedef struct {
    logic valid; logic [31:0] rs, rt, imm; logic [4:0] shamt; logic alu_src; logic [4:0] op;
    logic mw, mr; logic [1:0] size; logic [4:0] rd; logic [1:0] wb;
  } instr_t;

  typedef struct {
    logic [31:0] alu, st; logic [3:0] wr, rden; logic [4:0] dst; logic [1:0] wb; logic err;
    logic chk_alu, chk_st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_busy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] im, input logic src, input logic mw,
                                input logic mr, input logic [1:0] sz, input logic [4:0] rd,
                                input logic [1:0] wb);
    instr_t i;
    i.valid = 1'b1; i.rs = rs; i.rt = rt; i.imm = im; i.shamt = 5'd0; i.alu_src = src;
    i.op = op; i.mw = mw; i.mr = mr; i.size = sz; i.rd = rd; i.wb = wb;
    return i;
  endfunction

  function automatic logic [31:0] ref_alu(input instr_t in);
    logic [31:0] b;
    b = in.alu_src ? in.imm : in.rt;
    case (in.op)
      ALU_ADD:  return in.rs + b;
      ALU_SUB:  return in.rs - b;
      ALU_AND:  return in.rs & b;
      ALU_OR:   return in.rs | b;
      ALU_XOR:  return in.rs ^ b;
      ALU_NOR:  return ~(in.rs | b);
      ALU_SLT:  return (longint'($signed(in.rs)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'(in.rs) < longint'(b)) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << in.shamt;
      ALU_SRL:  return b >> in.shamt;
      ALU_SRA:  return 32'(longint'($signed(b)) >>> in.shamt);
      ALU_SLLV: return b << in.rs[4:0];
      ALU_SRLV: return b >> in.rs[4:0];
      ALU_SRAV: return 32'(longint'($signed(b)) >>> in.rs[4:0]);
      ALU_LUI:  return {in.imm[15:0], 16'h0000};
      ALU_MFHI: return m_hi;
      ALU_MFLO: return m_lo;
      default:  return 32'h0;
    endcase
  endfunction

  // One clock of stimulus: drive, check the combinational stall, predict the latched result
  task automatic cycle(input instr_t in, input logic do_rst, output logic exp_stall,
                       output logic dut_stall);
    exp_t e;
    logic issue, mis;
    logic [1:0] a;
    longint sa, sb;
    longint unsigned ua, ub;
    @(negedge clk);
    rst = do_rst; valid = in.valid; rs_data = in.rs; rt_data = in.rt; imm = in.imm;
    shamt = in.shamt; alu_src = in.alu_src; alu_op = in.op; mem_write = in.mw;
    mem_read = in.mr; mem_size = in.size; reg_dst = in.rd; wb_ctl = in.wb;
    #1;
    exp_stall = !do_rst && in.valid && (m_busy > 0) && is_hilo_op(in.op);
    dut_stall = o_stall;
    check("stall", {31'd0, o_stall}, {31'd0, exp_stall});
    e.alu = 0; e.st = 0; e.wr = 0; e.rden = 0; e.dst = 0; e.wb = 0; e.err = 0;
    e.chk_alu = 1'b0; e.chk_st = 1'b0;
    if (do_rst) begin
      e.chk_alu = 1'b1; e.chk_st = 1'b1;
      m_hi = 0; m_lo = 0; m_busy = 0;
    end else begin
      issue = in.valid && !exp_stall;
      e.alu = ref_alu(in);
      a = e.alu[1:0];
      mis = 1'b0;
      for (int k = 0; k < 4; k++)
        e.st[8*k +: 8] = (in.size == MEM_BYTE) ? in.rt[7:0] :
                         (in.size == MEM_HALF) ? in.rt[8*(k%2) +: 8] : in.rt[8*k +: 8];
      if (issue) begin
        logic [3:0] en;
        en = 4'h0;
        if (in.size == MEM_BYTE) en[a] = 1'b1;
        else if (in.size == MEM_HALF) begin
          if (a[0]) mis = 1'b1;
          else begin en[a] = 1'b1; en[int'(a) + 1] = 1'b1; end
        end else if (a != 2'b00) mis = 1'b1;
        else en = 4'hF;
        e.err = (in.mw || in.mr) && mis;
        e.dst = in.rd;
        e.wb = e.err ? 2'b00 : in.wb;
        e.wr = (in.mw && !e.err) ? en : 4'h0;
        e.rden = (in.mr && !in.mw && !e.err) ? en : 4'h0;
        e.chk_alu = 1'b1;
        e.chk_st = in.mw && !e.err;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
      if (issue) begin
        sa = longint'($signed(in.rs)); sb = longint'($signed(in.rt));
        ua = longint'(in.rs);          ub = longint'(in.rt);
        case (in.op)
          ALU_MTHI: m_hi = in.rs;
          ALU_MTLO: m_lo = in.rs;
          ALU_MULT:  begin {p_hi, p_lo} = 64'(sa * sb); m_busy = 1; end
          ALU_MULTU: begin {p_hi, p_lo} = 64'(ua * ub); m_busy = 1; end
          ALU_DIV, ALU_DIVU: begin
            if (in.rt == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = in.rs; end
            else if (in.op == ALU_DIV) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            else begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
            m_busy = 32;
          end
          default: ;
        endcase
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic issue_instr(input instr_t in, output int stalls);
    logic es, ds;
    int k;
    stalls = 0;
    for (k = 0; k < 100; k++) begin
      cycle(in, 1'b0, es, ds);
      if (ds) stalls++;
      if (!es) break;
    end
    if (k == 100) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: stalled %0d cycles, required under 100", k);
    end
  endtask

  instr_t nop_i;

  task automatic do_reset(input int n);
    logic es, ds;
    for (int k = 0; k < n; k++) cycle(nop_i, 1'b1, es, ds);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_alu) check("alu_data", o_alu_data, e.alu);
        if (e.chk_st) check("store_data", o_store_data, e.st);
        check("write_ctl", {28'd0, o_write_ctl}, {28'd0, e.wr});
        check("read_ctl", {28'd0, o_read_ctl}, {28'd0, e.rden});
        check("reg_dst", {27'd0, o_reg_dst}, {27'd0, e.dst});
        check("wb_ctl", {30'd0, o_wb_ctl}, {30'd0, e.wb});
        check("addr_err", {31'd0, o_addr_err}, {31'd0, e.err});
      end
    end
  end

  initial begin : driver
    instr_t in;
    int st;
    logic es, ds;
    nop_i = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, MEM_WORD, 0, 0);
    nop_i.valid = 1'b0;
    do_reset(2);

    issue_instr(mk(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, MEM_WORD, 5'd7, 2'b11), st);
    issue_instr(mk(ALU_ADD, 32'h100, 32'hAB, 32'h3, 1, 1, 0, MEM_BYTE, 5'd0, 2'b00), st);
    issue_instr(mk(ALU_ADD, 32'h100, 32'h1234_5678, 32'h2, 1, 1, 0, MEM_WORD, 5'd0, 2'b01), st);
    cycle(nop_i, 1'b0, es, ds);
    issue_instr(mk(ALU_ADD, 32'h200, 0, 32'h2, 1, 0, 1, MEM_HALF, 5'd3, 2'b11), st);
    issue_instr(mk(ALU_ADD, 32'h200, 0, 32'h1, 1, 0, 1, MEM_HALF, 5'd3, 2'b11), st);
    issue_instr(mk(ALU_ADD, 32'h300, 32'hBEEF, 32'h0, 1, 1, 1, MEM_HALF, 5'd3, 2'b10), st);

    issue_instr(mk(ALU_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0, MEM_WORD, 5'd0, 2'b00), st);
    issue_instr(mk(ALU_MFLO, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd8, 2'b01), st);
    n_cmp++;
    if (st != 32) begin
      n_bad++;
      $display("FAIL div_stall_cycles: got %0d expected 32", st);
    end
    issue_instr(mk(ALU_MFHI, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd9, 2'b01), st);

    issue_instr(mk(ALU_DIVU, 32'h55, 32'h0, 0, 0, 0, 0, MEM_WORD, 5'd0, 2'b00), st);
    issue_instr(mk(ALU_ADD, 32'h5, 32'h6, 0, 0, 0, 0, MEM_WORD, 5'd4, 2'b01), st);
    issue_instr(mk(ALU_MFLO, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd8, 2'b01), st);
    issue_instr(mk(ALU_MFHI, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd9, 2'b01), st);
    issue_instr(mk(ALU_MULT, 32'hFFFF_FFFE, 32'h3, 0, 0, 0, 0, MEM_WORD, 5'd0, 2'b00), st);
    issue_instr(mk(ALU_MFHI, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd9, 2'b01), st);
    issue_instr(mk(ALU_MFLO, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd8, 2'b01), st);

    issue_instr(mk(ALU_DIV, 32'h1234_5678, 32'h7, 0, 0, 0, 0, MEM_WORD, 5'd0, 2'b00), st);
    for (int k = 0; k < 9; k++)
      issue_instr(mk(ALU_ADD, k, 1, 0, 0, 0, 0, MEM_WORD, 5'd2, 2'b11), st);
    cycle(mk(ALU_ADD, 1, 1, 0, 0, 0, 0, MEM_WORD, 5'd2, 2'b11), 1'b1, es, ds);
    issue_instr(mk(ALU_MFLO, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd8, 2'b01), st);
    issue_instr(mk(ALU_MFHI, 0, 0, 0, 0, 0, 0, MEM_WORD, 5'd9, 2'b01), st);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in = mk(ALU_ADD, $urandom & 32'h0000_FFF0, $urandom, $urandom_range(0, 7), 1,
                1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 5'($urandom),
                2'($urandom));
      end else begin
        in = mk(5'($urandom_range(0, 22)), $urandom, $urandom, $urandom, 1'($urandom), 0, 0,
                MEM_WORD, 5'($urandom), 2'($urandom));
        in.shamt = 5'($urandom);
        if ($urandom_range(0, 7) == 0) in.rt = 0;
        if ($urandom_range(0, 7) == 0) in.rs = 32'h8000_0000;
      end
      in.valid = ($urandom_range(0, 7) != 0);
      if (in.valid) issue_instr(in, st);
      else cycle(in, 1'b0, es, ds);
    end

    for (int k = 0; k < 3; k++) cycle(nop_i, 1'b0, es, ds);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
